// File: rtl/keccak_pkg.sv
// Keccak constants shared by the absorb and squeeze datapaths: mode codes,
// per-mode rate sizes, output buffer size and the squeeze FSM encoding.
package keccak_pkg;
    localparam int BW_CTRL   = 2;
    localparam int MAX_OBYTE = 192;
    localparam int STATE_W   = 1600;
    localparam int LANE_W    = 64;

    localparam logic [BW_CTRL-1:0] SHAKE128 = 2'b00;
    localparam logic [BW_CTRL-1:0] SHAKE256 = 2'b01;
    localparam logic [BW_CTRL-1:0] SHA3_256 = 2'b10;
    localparam logic [BW_CTRL-1:0] SHA3_512 = 2'b11;

    localparam logic [7:0] RATE_BYTES_SHAKE128 = 8'd168;
    localparam logic [7:0] RATE_BYTES_SHAKE256 = 8'd136;
    localparam logic [7:0] RATE_BYTES_SHA3_256 = 8'd136;
    localparam logic [7:0] RATE_BYTES_SHA3_512 = 8'd72;

    localparam logic [4:0] RATE_LANES_SHAKE128 = 5'd21;
    localparam logic [4:0] RATE_LANES_SHAKE256 = 5'd17;
    localparam logic [4:0] RATE_LANES_SHA3_256 = 5'd17;
    localparam logic [4:0] RATE_LANES_SHA3_512 = 5'd9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_COPY = 3'd1,
        ST_PERM = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } sq_state_t;

    typedef struct packed {
        sq_state_t  state;
        logic [4:0] lane_idx;
        logic [7:0] out_off;
        logic [7:0] rate_bytes;
    } sq_dbg_t;

    function automatic logic [7:0] clamp_len(input logic [7:0] len);
        return (len > 8'(MAX_OBYTE)) ? 8'(MAX_OBYTE) : len;
    endfunction
endpackage

// File: rtl/keccak_squeeze_if.sv
// Squeeze-side bundle: start/length/state from the absorb side, the permutation
// request/response pair, and the assembled output with its completion pulse.
interface keccak_squeeze_if;
    import keccak_pkg::*;

    // Handshakes: i_start is accepted only while o_busy=0 (otherwise dropped);
    // o_perm_req is a one-cycle request answered later by i_perm_done with the
    // permuted state on i_state; o_valid is a one-cycle pulse with no backpressure.
    logic [BW_CTRL-1:0]     i_mode;
    logic [7:0]             i_obyte_len;
    logic                   i_start;
    logic [STATE_W-1:0]     i_state;
    logic                   i_perm_done;
    logic                   o_perm_req;
    logic [MAX_OBYTE*8-1:0] o_bytes;
    logic                   o_valid;
    logic                   o_busy;
    sq_dbg_t                dbg;

    modport master (
        output i_mode, i_obyte_len, i_start, i_state, i_perm_done,
        input  o_perm_req, o_bytes, o_valid, o_busy, dbg
    );

    modport slave (
        input  i_mode, i_obyte_len, i_start, i_state, i_perm_done,
        output o_perm_req, o_bytes, o_valid, o_busy, dbg
    );
endinterface

// File: rtl/keccak_rate_lut.sv
// Mode to rate lookup, in bytes and in 64-bit lanes.
module keccak_rate_lut
    import keccak_pkg::*;
(
    input  logic [BW_CTRL-1:0] mode,
    output logic [7:0]         rate_bytes,
    output logic [4:0]         rate_lanes
);
    always_comb begin
        rate_bytes = RATE_BYTES_SHAKE128;
        rate_lanes = RATE_LANES_SHAKE128;
        case (mode)
            SHAKE256: begin
                rate_bytes = RATE_BYTES_SHAKE256;
                rate_lanes = RATE_LANES_SHAKE256;
            end
            SHA3_256: begin
                rate_bytes = RATE_BYTES_SHA3_256;
                rate_lanes = RATE_LANES_SHA3_256;
            end
            SHA3_512: begin
                rate_bytes = RATE_BYTES_SHA3_512;
                rate_lanes = RATE_LANES_SHA3_512;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/keccak_squeeze.sv
// Squeeze phase: copies the rate part of the Keccak state into the output buffer
// one lane per cycle, requesting further permutations until len bytes are out.
module keccak_squeeze
    import keccak_pkg::*;
(
    input logic             i_clk,
    input logic             i_rst,
    keccak_squeeze_if.slave bus
);
    sq_state_t              state;
    sq_state_t              next_state;
    logic [STATE_W-1:0]     st_reg;
    logic [BW_CTRL-1:0]     mode_q;
    logic [7:0]             len_q;
    logic [7:0]             out_off;
    logic [4:0]             lane_idx;
    logic [MAX_OBYTE*8-1:0] bytes_q;
    logic                   valid_q;

    logic [7:0]             rate_bytes;
    logic [4:0]             rate_lanes;
    logic [7:0]             start_len;
    logic [7:0]             remain;
    logic [3:0]             copy_n;
    logic [7:0]             next_off;
    logic                   lane_last;
    logic [LANE_W-1:0]      lane;

    // Rate follows the latched mode so a mode change while busy has no effect.
    keccak_rate_lut u_rate_lut (
        .mode       (mode_q),
        .rate_bytes (rate_bytes),
        .rate_lanes (rate_lanes)
    );

    assign start_len = clamp_len(bus.i_obyte_len);
    assign lane      = st_reg[{lane_idx, 6'b000000} +: LANE_W];
    assign remain    = len_q - out_off;
    assign copy_n    = (remain >= 8'd8) ? 4'd8 : remain[3:0];
    assign next_off  = out_off + {4'b0000, copy_n};
    assign lane_last = (lane_idx + 5'd1 == rate_lanes);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Completion is checked before the lane wrap, so the last block never
    // triggers a spare permutation.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (bus.i_start) next_state = (start_len == 8'd0) ? ST_DONE : ST_COPY;
            ST_COPY: begin
                if (next_off == len_q) next_state = ST_DONE;
                else if (lane_last)    next_state = ST_PERM;
            end
            ST_PERM: next_state = ST_WAIT;
            ST_WAIT: if (bus.i_perm_done) next_state = ST_COPY;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_reg   <= '0;
            mode_q   <= '0;
            len_q    <= '0;
            out_off  <= '0;
            lane_idx <= '0;
            bytes_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: if (bus.i_start) begin
                    mode_q   <= bus.i_mode;
                    len_q    <= start_len;
                    st_reg   <= bus.i_state;
                    bytes_q  <= '0;
                    out_off  <= '0;
                    lane_idx <= '0;
                end
                ST_COPY: begin
                    // A partial final lane writes only its low bytes.
                    for (int j = 0; j < 8; j++) begin
                        if (4'(j) < copy_n)
                            bytes_q[{out_off + 8'(j), 3'b000} +: 8] <= lane[6'(8 * j) +: 8];
                    end
                    out_off  <= next_off;
                    lane_idx <= lane_idx + 5'd1;
                end
                ST_WAIT: if (bus.i_perm_done) begin
                    st_reg   <= bus.i_state;
                    lane_idx <= '0;
                end
                ST_DONE: valid_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.o_bytes    = bytes_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_perm_req = (state == ST_PERM);
    assign bus.o_busy     = (state != ST_IDLE);
    assign bus.dbg        = '{state: state, lane_idx: lane_idx, out_off: out_off, rate_bytes: rate_bytes};
endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed and randomized squeeze runs checked against a byte-level model of
// the rate-block output stream and a cycle-count formula.
module tb_keccak_squeeze;
    import keccak_pkg::*;

    localparam int MAXB = 192;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   failures;

    logic [1599:0]       blk [3];
    logic [MAXB*8-1:0]   got;
    logic [MAXB*8-1:0]   r192;
    logic [1599:0]       junk;

    keccak_squeeze_if bus ();

    keccak_squeeze dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int rate_of(input logic [1:0] mode);
        case (mode)
            2'b00:   return 168;
            2'b01:   return 136;
            2'b10:   return 136;
            default: return 72;
        endcase
    endfunction

    // Output byte j is byte (j mod rate) of the (j div rate)-th state delivered.
    function automatic logic [MAXB*8-1:0] model_bytes(input int len, input int rate);
        logic [MAXB*8-1:0] r;
        r = '0;
        for (int j = 0; j < len; j++)
            r[11'(j * 8) +: 8] = blk[2'(j / rate)][11'((j % rate) * 8) +: 8];
        return r;
    endfunction

    task automatic rand_state(output logic [1599:0] v);
        for (int w = 0; w < 50; w++) v[11'(w * 32) +: 32] = $urandom;
    endtask

    task automatic fill_byte(output logic [1599:0] v, input logic [7:0] b);
        v = {200{b}};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bytes(input string tag, input logic [MAXB*8-1:0] obs, input logic [MAXB*8-1:0] exp);
        int first;
        logic [7:0] ob;
        logic [7:0] eb;
        first = -1;
        ob = '0;
        eb = '0;
        for (int j = MAXB - 1; j >= 0; j--)
            if (obs[11'(j * 8) +: 8] !== exp[11'(j * 8) +: 8]) first = j;
        if (first >= 0) begin
            ob = obs[11'(first * 8) +: 8];
            eb = exp[11'(first * 8) +: 8];
        end
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s first_bad_byte=%0d observed=%02h expected=%02h", tag, first, ob, eb);
        end
    endtask

    // One squeeze operation, driven from a negedge; blk[] must hold the states.
    task automatic run_op(input string tag, input logic [1:0] mode, input int len, input int dly,
                          input bit dup_start, input bit stray_done, output logic [MAXB*8-1:0] res);
        int l, rate, nperm, exp_cyc, cyc, perms, cd, blk_i, valid_cyc, first_req;
        bit busy_bad;
        logic busy_at_valid;
        logic [MAXB*8-1:0] exp;
        l         = (len > MAXB) ? MAXB : len;
        rate      = rate_of(mode);
        nperm     = (l == 0) ? 0 : (l - 1) / rate;
        exp_cyc   = (l + 7) / 8 + 1 + nperm * (1 + dly);
        exp       = model_bytes(l, rate);
        perms     = 0;
        cd        = -1;
        blk_i     = 1;
        valid_cyc = -1;
        first_req = -1;
        busy_bad  = 1'b0;
        busy_at_valid = 1'b1;
        res       = '0;

        bus.i_mode      = mode;
        bus.i_obyte_len = 8'(len);
        bus.i_state     = blk[0];
        bus.i_start     = 1'b1;
        @(posedge i_clk);
        cyc = 0;
        while (cyc <= exp_cyc + 40 && valid_cyc < 0) begin
            @(negedge i_clk);
            bus.i_start     = 1'b0;
            bus.i_perm_done = 1'b0;
            rand_state(junk);
            bus.i_state     = junk;
            if (bus.o_valid === 1'b1) begin
                valid_cyc     = cyc;
                busy_at_valid = bus.o_busy;
                res           = bus.o_bytes;
            end else if (bus.o_busy !== 1'b1) begin
                busy_bad = 1'b1;
            end
            if (cd > 0) cd--;
            if (bus.o_perm_req === 1'b1) begin
                perms++;
                if (first_req < 0) first_req = cyc;
                cd = dly;
            end
            if (cd == 0) begin
                bus.i_perm_done = 1'b1;
                bus.i_state     = blk[2'(blk_i)];
                blk_i++;
                cd = -1;
            end else if (cyc == 2 && stray_done) begin
                bus.i_perm_done = 1'b1;
            end
            if (cyc == 2 && dup_start) begin
                bus.i_start     = 1'b1;
                bus.i_mode      = ~mode;
                bus.i_obyte_len = 8'd8;
            end
            cyc++;
        end
        bus.i_start     = 1'b0;
        bus.i_perm_done = 1'b0;

        chk($sformatf("%s valid_cycle", tag), 32'(valid_cyc), 32'(exp_cyc));
        chk($sformatf("%s perm_reqs", tag), 32'(perms), 32'(nperm));
        if (nperm > 0)
            chk($sformatf("%s first_perm_cycle", tag), 32'(first_req), 32'(rate / 8));
        chk($sformatf("%s busy_while_running", tag), 32'(busy_bad), 32'd0);
        chk($sformatf("%s busy_at_valid", tag), 32'(busy_at_valid), 32'd0);
        chk_bytes($sformatf("%s bytes", tag), res, exp);

        @(negedge i_clk);
        chk($sformatf("%s valid_one_pulse", tag), 32'(bus.o_valid), 32'd0);
        chk_bytes($sformatf("%s bytes_hold", tag), bus.o_bytes, exp);
    endtask

    initial begin
        int p;
        logic [1:0] m;
        checks   = 0;
        failures = 0;

        i_rst           = 1'b1;
        bus.i_mode      = '0;
        bus.i_obyte_len = '0;
        bus.i_start     = 1'b0;
        bus.i_state     = '0;
        bus.i_perm_done = 1'b0;
        #1;
        chk("reset o_valid", 32'(bus.o_valid), 32'd0);
        chk("reset o_busy", 32'(bus.o_busy), 32'd0);
        chk("reset o_perm_req", 32'(bus.o_perm_req), 32'd0);
        chk_bytes("reset o_bytes", bus.o_bytes, '0);
        chk("reset fsm idle", 32'(bus.dbg.state), 32'(ST_IDLE));
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // SHA3_512, 64 bytes of a k&0xFF state: one rate block, no permutation.
        for (int k = 0; k < 200; k++) blk[0][11'(k * 8) +: 8] = 8'(k);
        run_op("sha3_512_len64", 2'b11, 64, 1, 1'b0, 1'b0, got);
        chk("sha3_512_len64 byte63", 32'(got[511:504]), 32'h3F);

        // SHAKE256, 33 bytes: last lane contributes a single byte; stray perm_done in COPY.
        rand_state(blk[0]);
        run_op("shake256_len33", 2'b01, 33, 1, 1'b0, 1'b1, got);

        // SHAKE128, 192 bytes across one permutation; a second start while busy.
        fill_byte(blk[0], 8'hA5);
        fill_byte(blk[1], 8'h3C);
        run_op("shake128_len192", 2'b00, 192, 4, 1'b1, 1'b0, r192);
        chk("shake128_len192 byte167", 32'(r192[167*8 +: 8]), 32'hA5);
        chk("shake128_len192 byte168", 32'(r192[168*8 +: 8]), 32'h3C);

        run_op("len0", 2'b00, 0, 1, 1'b0, 1'b0, got);
        run_op("len250", 2'b00, 250, 4, 1'b0, 1'b0, got);
        chk_bytes("len250 equals len192", got, r192);

        for (int t = 0; t < 8; t++) begin
            rand_state(blk[0]);
            rand_state(blk[1]);
            rand_state(blk[2]);
            m = 2'($urandom_range(0, 3));
            run_op($sformatf("rand%0d", t), m, int'($urandom_range(0, 255)),
                   int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 1'b0, got);
        end

        // Reset while waiting on the permutation core.
        rand_state(blk[0]);
        bus.i_mode      = 2'b00;
        bus.i_obyte_len = 8'd192;
        bus.i_state     = blk[0];
        bus.i_start     = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        p = 0;
        while (p < 60 && bus.o_perm_req !== 1'b1) begin
            @(negedge i_clk);
            p++;
        end
        chk("midwait perm_req seen", 32'(bus.o_perm_req), 32'd1);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midwait rst o_perm_req", 32'(bus.o_perm_req), 32'd0);
        chk("midwait rst o_valid", 32'(bus.o_valid), 32'd0);
        chk("midwait rst o_busy", 32'(bus.o_busy), 32'd0);
        chk_bytes("midwait rst o_bytes", bus.o_bytes, '0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        rand_state(blk[0]);
        run_op("after_reset sha3_256_len32", 2'b10, 32, 1, 1'b0, 1'b0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
- Squeeze-side counterpart of the absorb datapath in the Keccak/SHA-3 core.
- After the absorb phase hands over a permuted 1600-bit state, this block extracts i_obyte_len output bytes from the rate portion, lane by lane.
- When more bytes are needed than one rate block holds, it requests further permutations from the permutation core.
- It assembles the result into a 192-byte output buffer for the Kyber hash/XOF consumers.

Parameters:
- BW_CTRL, 2, width of i_mode.
- MAX_OBYTE, 192, output buffer size in bytes.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, asynchronous active-high reset.
- i_mode, input, BW_CTRL, 00 SHAKE128, 01 SHAKE256, 10 SHA3_256, 11 SHA3_512.
- i_obyte_len, input, 8, requested output length in bytes.
- i_start, input, 1, start pulse; i_state holds the first permuted state.
- i_state, input, 1600, Keccak state; byte k = i_state[8k+7:8k].
- i_perm_done, input, 1, permutation core result valid on i_state.
- o_perm_req, output, 1, one-cycle request to permute the current state.
- o_bytes, output, MAX_OBYTE*8, output byte j = o_bytes[8j+7:8j].
- o_valid, output, 1, one-cycle pulse: o_bytes complete.
- o_busy, output, 1, high from accepted start until o_valid.

Behaviour:
- Reset (async, i_rst=1): FSM to IDLE; o_bytes=0, o_valid=0, o_perm_req=0, o_busy=0; all counters and the latched state cleared. Reset mid-operation aborts without producing o_valid.
- Rate in bytes / lanes: SHAKE128 168/21, SHAKE256 136/17, SHA3_256 136/17, SHA3_512 72/9.
- Length: len = min(i_obyte_len, MAX_OBYTE). Values 193..255 are clamped to 192.
- IDLE: on i_start=1 at edge E0:
  - latch mode, rate and len; latch i_state into the internal state register;
  - clear o_bytes, out_off and lane_idx; set o_busy=1.
  - If len=0, go to DONE; otherwise go to COPY.
- COPY: one 8-byte lane per cycle. Lane lane_idx = state[64*lane_idx+63:64*lane_idx] is written to o_bytes starting at byte out_off.
  - Only min(8, len-out_off) bytes are written; a partial final lane writes its low bytes only.
  - out_off += bytes written; lane_idx += 1.
  - If out_off reaches len, go to DONE.
  - Else if lane_idx reaches rate/8, go to PERM.
- PERM: o_perm_req=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until i_perm_done=1 is sampled. At that edge latch i_state, set lane_idx=0, return to COPY.
- DONE: o_valid=1 for one cycle, o_busy=0, return to IDLE. o_bytes holds its value until the next accepted i_start.
- Latency, no permutation: o_valid is high in the cycle after edge E(N+1), where N = ceil(len/8). Each permutation adds 1 PERM cycle plus the WAIT duration.
- Bytes at index >= len stay 0.
- i_start while o_busy=1 is ignored.
- i_perm_done outside WAIT is ignored.
- i_perm_done on the same edge as entering WAIT is not possible, because PERM precedes WAIT.
- o_perm_req is never asserted when the remaining byte count is 0; the final rate block never triggers a spare permutation.

Decomposition:
- keccak_pkg holds the mode localparams (SHAKE128, SHAKE256, SHA3_256, SHA3_512), the RATE_BYTES/RATE_LANES constants per mode, MAX_OBYTE, and the FSM state encoding. The absorb block shares this package.
- One natural sub-module, keccak_rate_lut: combinational mode -> {rate_bytes, rate_lanes}, also reusable by the absorb side.
- The lane select and byte-masked write stay in keccak_squeeze.

Test Plan:
- SHA3_512, len=64, state bytes k=k&0xFF:
  - o_bytes[0..63]=0x00..0x3F and bytes 64..191=0;
  - o_perm_req never asserted;
  - o_valid exactly one pulse, in the cycle after E9.
- SHAKE256, len=33:
  - 5 COPY cycles; last lane writes 1 byte, so o_bytes[32]=state byte 32;
  - bytes 33..191 = 0.
- SHAKE128, len=192, first state bytes=0xA5, i_perm_done driven 4 cycles after o_perm_req with second state bytes=0x3C:
  - exactly one o_perm_req pulse after 21 lanes;
  - bytes 0..167=0xA5, bytes 168..191=0x3C.
- len=0, and separately len=250:
  - len=0: o_valid one cycle after start (after E1), o_bytes all 0, no o_perm_req;
  - len=250: clamped to 192, result identical to the len=192 case.
- Reset mid-WAIT:
  - o_perm_req, o_valid, o_busy and o_bytes go 0 immediately, without waiting for a clock edge;
  - a later start with SHA3_256 and len=32 completes normally with 4 lanes.
- Protocol robustness:
  - a second i_start while busy is ignored and the first result is unchanged;
  - i_perm_done pulsed during COPY has no effect.
